// File: rtl/idiv_iter_if.sv
// Operand/result bundle between the scheduler and the iterative divider.
interface idiv_iter_if #(
  parameter int unsigned W_OP = 3
);
  logic            en;
  logic            kill;
  logic [W_OP-1:0] op;
  logic [64:0]     R;
  logic [64:0]     C;
  logic            busy;
  logic            rdy;
  logic [64:0]     Res;
  logic [5:0]      flg;

  modport master (output en, kill, op, R, C, input busy, rdy, Res, flg);
  modport slave  (input en, kill, op, R, C, output busy, rdy, Res, flg);
endinterface

// File: rtl/idiv_iter.sv
// Radix-2 restoring integer divider, one quotient bit per enabled cycle,
// returning quotient or remainder with an x86-style flag vector.
module idiv_iter #(
  parameter int unsigned W_OP = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  idiv_iter_if.slave  bus
);
  localparam int unsigned W_DAT = 64;
  localparam int unsigned W_CNT = 7;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;

  state_e             state_q, state_d;
  logic [W_OP-1:0]    op_q, op_d;
  logic [W_DAT-1:0]   q_q, q_d;
  logic [W_DAT-1:0]   p_q, p_d;
  logic [W_DAT-1:0]   d_q, d_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               sc_q, sc_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;
  logic [W_DAT:0]     res_q, res_d;
  logic [5:0]         flg_q, flg_d;

  // Start-edge operand preparation (uses the live op bus)
  logic [W_DAT-1:0]   st_mask, st_min, st_rn, st_cn, st_absr, st_absc;
  logic               st_sr, st_sc, st_dz, st_ovf;

  always_comb begin
    st_mask = bus.op[2] ? 64'h0000_0000_FFFF_FFFF : '1;
    st_min  = bus.op[2] ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
    st_rn   = bus.R[W_DAT-1:0] & st_mask;
    st_cn   = bus.C[W_DAT-1:0] & st_mask;
    st_sr   = bus.op[0] & (bus.op[2] ? bus.R[31] : bus.R[63]);
    st_sc   = bus.op[0] & (bus.op[2] ? bus.C[31] : bus.C[63]);
    st_absr = st_sr ? ((~st_rn + 64'd1) & st_mask) : st_rn;
    st_absc = st_sc ? ((~st_cn + 64'd1) & st_mask) : st_cn;
    st_dz   = (st_cn == '0);
    st_ovf  = bus.op[0] && (st_rn == st_min) && (st_cn == st_mask);
  end

  // One restoring step on the current partial remainder/quotient
  logic [W_DAT-1:0]   mask;
  logic               q_msb, ge;
  logic [W_DAT:0]     sh, diff;
  logic [W_DAT-1:0]   p_step, q_step;

  always_comb begin
    mask   = op_q[2] ? 64'h0000_0000_FFFF_FFFF : '1;
    q_msb  = op_q[2] ? q_q[31] : q_q[63];
    sh     = {p_q, q_msb};
    diff   = sh - {1'b0, d_q};
    ge     = (sh >= {1'b0, d_q});
    p_step = ge ? diff[W_DAT-1:0] : sh[W_DAT-1:0];
    q_step = {q_q[W_DAT-2:0], ge};
  end

  // The final quotient bit is resolved in FIX, so the loop leaves ITER at count 2->1
  logic [W_DAT-1:0]   qf, pf, sel, val;
  logic               neg;

  always_comb begin
    qf  = sc_q ? q_q : q_step;
    pf  = sc_q ? p_q : p_step;
    sel = op_q[1] ? pf : qf;
    neg = ~sc_q & (op_q[1] ? rneg_q : qneg_q);
    val = (neg ? (~sel + 64'd1) : sel) & mask;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    q_d     = q_q;
    p_d     = p_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    sc_d    = sc_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    rdy_d   = 1'b0;
    res_d   = res_q;
    flg_d   = flg_q;

    if (bus.kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            op_d   = bus.op;
            qneg_d = st_sr ^ st_sc;
            rneg_d = st_sr;
            d_d    = st_absc;
            cnt_d  = bus.op[2] ? W_CNT'(32) : W_CNT'(64);
            dz_d   = st_dz;
            ovf_d  = ~st_dz & st_ovf;
            sc_d   = st_dz | st_ovf;
            if (st_dz) begin
              q_d     = st_mask;
              p_d     = st_rn;
              state_d = FIX;
            end else if (st_ovf) begin
              q_d     = st_min;
              p_d     = '0;
              state_d = FIX;
            end else begin
              q_d     = st_absr;
              p_d     = '0;
              state_d = ITER;
            end
          end
        end
        ITER: begin
          p_d   = p_step;
          q_d   = q_step;
          cnt_d = cnt_q - W_CNT'(1);
          if (cnt_q == W_CNT'(2)) state_d = FIX;
        end
        FIX: begin
          res_d   = {1'b0, val};
          flg_d   = {dz_q, ovf_q, 1'b0, (op_q[2] ? val[31] : val[63]),
                     (val == '0), ~^val[7:0]};
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      q_q     <= '0;
      p_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      sc_q    <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else if (clkEn) begin
      state_q <= state_d;
      op_q    <= op_d;
      q_q     <= q_d;
      p_q     <= p_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      sc_q    <= sc_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  // Pointer tags on the operand buses carry no arithmetic meaning
  logic unused_tag;
  assign unused_tag = bus.R[64] ^ bus.C[64];

  assign bus.busy = busy_q;
  assign bus.rdy  = rdy_q;
  assign bus.Res  = res_q;
  assign bus.flg  = flg_q;
endmodule

// File: tb/tb_idiv_iter.sv
// Bench for idiv_iter: directed vector table, randomized ops against an
// arithmetic reference, and hand sequences for stall, kill, reset, back-to-back.
module tb_idiv_iter;
  logic clk;
  logic rst;
  logic clkEn;

  idiv_iter_if #(.W_OP(3)) bus ();

  idiv_iter #(.W_OP(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .clkEn (clkEn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [64:0] r;
    logic [64:0] c;
    logic [64:0] res;
    logic [5:0]  flg;
    int          lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: truncating division, shortcut rules, flags
  function automatic void model(input logic [2:0] op, input logic [64:0] r, input logic [64:0] c,
                                output logic [64:0] res, output logic [5:0] flg, output int lat);
    logic [63:0] msk, mn, rv, cv, v;
    logic        dz, ovf;
    int          a32, b32;
    longint      a64, b64;
    msk = op[2] ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    mn  = op[2] ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
    rv  = r[63:0] & msk;
    cv  = c[63:0] & msk;
    dz  = (cv == 64'd0);
    ovf = !dz && op[0] && rv == mn && cv == msk;
    if (dz)             v = op[1] ? rv : msk;
    else if (ovf)       v = op[1] ? 64'd0 : mn;
    else if (!op[0])    v = op[1] ? rv % cv : rv / cv;
    else if (op[2]) begin
      a32 = $signed(rv[31:0]);
      b32 = $signed(cv[31:0]);
      v   = {32'd0, 32'(op[1] ? a32 % b32 : a32 / b32)};
    end else begin
      a64 = $signed(rv);
      b64 = $signed(cv);
      v   = 64'(op[1] ? a64 % b64 : a64 / b64);
    end
    res = {1'b0, v};
    flg = {dz, ovf, 1'b0, (op[2] ? v[31] : v[63]), (v == 64'd0), ~^v[7:0]};
    lat = (dz || ovf) ? 2 : (op[2] ? 33 : 65);
  endfunction

  // Issue one op and wait (bounded) for rdy; latency counts cycles after the start cycle
  task automatic run_op(input logic [2:0] op, input logic [64:0] r, input logic [64:0] c,
                        output logic [64:0] res, output logic [5:0] f, output int lat,
                        output logic busy_bad);
    bus.en = 1'b1; bus.op = op; bus.R = r; bus.C = c;
    tick();
    bus.en = 1'b0;
    lat = 1;
    busy_bad = 1'b0;
    while (!bus.rdy && lat < 200) begin
      if (!bus.busy) busy_bad = 1'b1;
      tick();
      lat++;
    end
    if (bus.busy) busy_bad = 1'b1;
    res = bus.Res;
    f   = bus.flg;
  endtask

  vec_t        vecs[10];
  logic [64:0] res, eres, prior;
  logic [5:0]  f, ef;
  int          lat, elat, rdy_cnt;
  logic        bb, busy_seen;
  logic [2:0]  rop;
  logic [64:0] rr, rc;

  initial begin
    vecs[0] = '{3'b000, 65'd100, 65'd7, 65'd14, 6'b000000, 65};
    vecs[1] = '{3'b010, 65'd100, 65'd7, 65'd2,  6'b000000, 65};
    vecs[2] = '{3'b101, 65'h0_0000_0000_FFFF_FFF9, 65'd2, 65'h0_0000_0000_FFFF_FFFD, 6'b000100, 33};
    vecs[3] = '{3'b111, 65'h0_0000_0000_FFFF_FFF9, 65'd2, 65'h0_0000_0000_FFFF_FFFF, 6'b000101, 33};
    vecs[4] = '{3'b000, 65'd5, 65'd0, 65'h0_FFFF_FFFF_FFFF_FFFF, 6'b100101, 2};
    vecs[5] = '{3'b010, 65'd5, 65'd0, 65'd5, 6'b100001, 2};
    vecs[6] = '{3'b001, 65'h0_8000_0000_0000_0000, 65'h0_FFFF_FFFF_FFFF_FFFF,
                65'h0_8000_0000_0000_0000, 6'b010101, 2};
    vecs[7] = '{3'b000, 65'd0, 65'd3, 65'd0, 6'b000011, 65};
    vecs[8] = '{3'b000, 65'h1_0000_0000_0000_0064, 65'h1_0000_0000_0000_0007, 65'd14, 6'b000000, 65};
    vecs[9] = '{3'b100, 65'd5, 65'h0_0000_0001_0000_0000, 65'h0_0000_0000_FFFF_FFFF, 6'b100101, 2};

    rst = 1'b0; clkEn = 1'b1;
    bus.en = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.R = '0; bus.C = '0;
    tick(); tick();
    check("reset_busy", {64'd0, bus.busy}, 65'd0);
    check("reset_rdy",  {64'd0, bus.rdy},  65'd0);
    check("reset_res",  bus.Res, 65'd0);
    check("reset_flg",  {59'd0, bus.flg}, 65'd0);
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].r, vecs[i].c, res, f, lat, bb);
      check($sformatf("vec%0d_res", i), res, vecs[i].res);
      check($sformatf("vec%0d_flg", i), {59'd0, f}, {59'd0, vecs[i].flg});
      check($sformatf("vec%0d_lat", i), 65'(lat), 65'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), {64'd0, bb}, 65'd0);
    end

    // Randomized ops against the reference
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rr  = {1'($urandom), $urandom, $urandom};
      rc  = {1'($urandom), $urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rc = {1'($urandom), (rop[2] ? {$urandom, 32'd0} : 64'd0)};
        1: begin
          rr = rop[2] ? {1'($urandom), $urandom, 32'h8000_0000} : 65'h0_8000_0000_0000_0000;
          rc = rop[2] ? {1'($urandom), $urandom, 32'hFFFF_FFFF} : 65'h0_FFFF_FFFF_FFFF_FFFF;
        end
        2: rc = 65'($urandom_range(1, 15));
        3: rc = {1'b0, {$urandom, $urandom} >> $urandom_range(0, 63)};
        default: ;
      endcase
      model(rop, rr, rc, eres, ef, elat);
      run_op(rop, rr, rc, res, f, lat, bb);
      check($sformatf("rnd%0d_res op=%b", i, rop), res, eres);
      check($sformatf("rnd%0d_flg", i), {59'd0, f}, {59'd0, ef});
      check($sformatf("rnd%0d_lat", i), 65'(lat), 65'(elat));
    end

    // Stall 10 cycles mid-ITER, then hold rdy while stalled in the rdy cycle
    bus.en = 1'b1; bus.op = 3'b000; bus.R = 65'd100; bus.C = 65'd7;
    tick();
    bus.en = 1'b0;
    lat = 1;
    while (lat < 20) begin tick(); lat++; end
    clkEn = 1'b0;
    busy_seen = 1'b1;
    repeat (10) begin tick(); lat++; busy_seen &= bus.busy; end
    check("stall_busy_held", {64'd0, busy_seen}, 65'd1);
    clkEn = 1'b1;
    while (!bus.rdy && lat < 200) begin tick(); lat++; end
    check("stall_lat", 65'(lat), 65'd75);
    check("stall_res", bus.Res, 65'd14);
    clkEn = 1'b0;
    repeat (3) tick();
    check("stall_rdy_hold", {64'd0, bus.rdy}, 65'd1);
    clkEn = 1'b1;
    tick();
    check("rdy_pulse_end", {64'd0, bus.rdy}, 65'd0);

    // Kill at k+20: no rdy, Res keeps the prior result
    prior = bus.Res;
    bus.en = 1'b1; bus.op = 3'b000; bus.R = 65'd100; bus.C = 65'd1;
    tick();
    bus.en = 1'b0;
    lat = 1;
    while (lat < 20) begin tick(); lat++; end
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    check("kill_busy", {64'd0, bus.busy}, 65'd0);
    rdy_cnt = 0;
    repeat (80) begin tick(); if (bus.rdy) rdy_cnt++; end
    check("kill_no_rdy", 65'(rdy_cnt), 65'd0);
    check("kill_res_hold", bus.Res, prior);

    // Kill together with en in IDLE blocks the start
    bus.en = 1'b1; bus.kill = 1'b1;
    tick();
    bus.en = 1'b0; bus.kill = 1'b0;
    check("kill_en_idle", {64'd0, bus.busy}, 65'd0);

    // Asynchronous reset mid-operation at k+30
    bus.en = 1'b1; bus.op = 3'b000; bus.R = 65'd999; bus.C = 65'd3;
    tick();
    bus.en = 1'b0;
    lat = 1;
    while (lat < 30) begin tick(); lat++; end
    #2 rst = 1'b0;
    #1;
    check("rst_busy", {64'd0, bus.busy}, 65'd0);
    check("rst_rdy",  {64'd0, bus.rdy},  65'd0);
    check("rst_res",  bus.Res, 65'd0);
    check("rst_flg",  {59'd0, bus.flg}, 65'd0);
    #1 rst = 1'b1;

    // First start after reset, then a second start in the first op's rdy cycle
    run_op(3'b000, 65'd1000, 65'd10, res, f, lat, bb);
    check("b2b_a_res", res, 65'd100);
    check("b2b_a_lat", 65'(lat), 65'd65);
    model(3'b101, 65'h0_0000_0000_FFFF_FF9C, 65'd7, eres, ef, elat);
    run_op(3'b101, 65'h0_0000_0000_FFFF_FF9C, 65'd7, res, f, lat, bb);
    check("b2b_b_res", res, eres);
    check("b2b_b_flg", {59'd0, f}, {59'd0, ef});
    check("b2b_b_lat", 65'(lat), 65'd33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
